// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: exception sources and CSR values in; CSR load strobes,
// flush and fetch redirect out.
interface trap_ctrl_if;
  logic        fetch_misalign_i;
  logic        illegal_instr_i;
  logic        csr_exception_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic [31:0] excep_pc_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        fetch_ready_i;
  logic        load_mcause_o;
  logic [31:0] excep_code_o;
  logic        load_mepc_o;
  logic [31:0] mepc_val_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    output fetch_misalign_i, illegal_instr_i, csr_exception_i, ecall_i, ebreak_i,
           mret_i, excep_pc_i, mtvec_i, mepc_i, fetch_ready_i,
    input  load_mcause_o, excep_code_o, load_mepc_o, mepc_val_o, flush_o,
           redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  fetch_misalign_i, illegal_instr_i, csr_exception_i, ecall_i, ebreak_i,
           mret_i, excep_pc_i, mtvec_i, mepc_i, fetch_ready_i,
    output load_mcause_o, excep_code_o, load_mepc_o, mepc_val_o, flush_o,
           redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: prioritises exceptions/mret, strobes mcause/mepc,
// flushes the pipeline for FLUSH_CYCLES cycles, then redirects fetch.
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input logic        clk_i,
  input logic        rst_n_i,
  trap_ctrl_if.slave bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  flush_cnt;
  logic              load_mcause_q;
  logic              load_mepc_q;
  logic [XLEN-1:0]   excep_code_q;
  logic [XLEN-1:0]   mepc_val_q;
  logic              flush_q;
  logic              redirect_valid_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic              busy_q;

  logic              exc_c;
  logic              trig_c;
  logic [XLEN-1:0]   code_c;
  logic [XLEN-1:0]   target_c;

  // Cause priority and redirect target for the current cycle's requests
  always_comb begin
    exc_c    = bus.fetch_misalign_i | bus.illegal_instr_i | bus.csr_exception_i |
               bus.ebreak_i | bus.ecall_i;
    trig_c   = exc_c | bus.mret_i;
    code_c   = XLEN'(11);
    if (bus.fetch_misalign_i)                           code_c = XLEN'(0);
    else if (bus.illegal_instr_i | bus.csr_exception_i) code_c = XLEN'(2);
    else if (bus.ebreak_i)                              code_c = XLEN'(3);
    target_c = exc_c ? (bus.mtvec_i & ~XLEN'(3)) : bus.mepc_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      flush_cnt        <= '0;
      load_mcause_q    <= 1'b0;
      load_mepc_q      <= 1'b0;
      excep_code_q     <= '0;
      mepc_val_q       <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      load_mcause_q <= 1'b0;
      load_mepc_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_c) begin
            state         <= FLUSH;
            flush_cnt     <= CNT_W'(FLUSH_CYCLES - 1);
            flush_q       <= 1'b1;
            busy_q        <= 1'b1;
            load_mcause_q <= exc_c;
            load_mepc_q   <= exc_c;
            redirect_pc_q <= target_c;
            // mcause/mepc values only change for exceptions; mret leaves them alone
            if (exc_c) begin
              excep_code_q <= code_c;
              mepc_val_q   <= bus.excep_pc_i;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state            <= REDIRECT;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        REDIRECT: begin
          if (bus.fetch_ready_i) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_mcause_o    = load_mcause_q;
  assign bus.load_mepc_o      = load_mepc_q;
  assign bus.excep_code_o     = excep_code_q;
  assign bus.mepc_val_o       = mepc_val_q;
  assign bus.flush_o          = flush_q;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.busy_o           = busy_q;
endmodule
